rv32i_fetch_unit: RTL and testbench
===================================

Name: rv32i_fetch_unit

Overview:
- Instruction fetch stage placed directly upstream of the pipelined RV32I datapath decode register.
- Issues word-aligned requests to instruction memory through a valid/ready request channel with in-order, variable-latency responses.
- Buffers returned instructions, together with their PC, in a small prefetch FIFO and presents them to decode.
- Honours decode stall and branch/jump redirect, discarding stale in-flight responses after a redirect.

Parameters:
- DEPTH, 4, number of prefetch FIFO entries and maximum number of outstanding requests (power of 2, at least 2).
- RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- resetn_i  in  1  reset, asynchronous, active-low.
- imem_req_valid_o  out  1  fetch request valid.
- imem_req_ready_i  in  1  instruction memory accepts the request.
- imem_add_o  out  32  request address, bits [1:0] always 0.
- imem_rsp_valid_i  in  1  response valid, in request order.
- imem_rsp_data_i  in  32  returned instruction word.
- stall_i  in  1  decode cannot accept this cycle.
- redirect_i  in  1  one-cycle flush request from branch/jump resolution.
- redirect_pc_i  in  32  new fetch target.
- valid_o  out  1  inst_o, pc_o and pc_plus4_o are valid.
- inst_o  out  32  instruction at the FIFO head.
- pc_o  out  32  PC of inst_o.
- pc_plus4_o  out  32  pc_o + 4, modulo 2^32.

Behaviour:
- Reset:
  - pc_fetch_r = RESET_PC; FIFO empty; outstanding = 0; discard = 0.
  - imem_req_valid_o = 0, valid_o = 0, inst_o = 0, pc_o = 0, pc_plus4_o = 4.
- Request issue:
  - imem_req_valid_o = !redirect_i && (fifo_count + outstanding < DEPTH).
  - imem_add_o = pc_fetch_r.
  - On handshake (valid && ready): pc_fetch_r += 4, wrapping at 2^32; outstanding increments.
  - The issued PC is pushed into a DEPTH-entry PC tag queue.
- Response handling:
  - Every imem_rsp_valid_i pulse decrements outstanding and pops the tag queue.
  - If discard > 0, the word is dropped and discard decrements.
  - Otherwise {tag, data} is written to the FIFO.
  - Space is guaranteed by the issue rule, so overflow is impossible by construction.
  - A response arriving while outstanding = 0 is ignored, and no counter underflows.
- Output and handshake:
  - valid_o = !fifo_empty && !redirect_i.
  - A pop occurs when valid_o && !stall_i.
  - There is no combinational path from imem_rsp_* to valid_o/inst_o.
  - Minimum latency from request handshake to valid_o is response latency + 1 cycle: responses are registered into the FIFO first.
- Simultaneous events in one cycle:
  - Push and pop together leave fifo_count unchanged.
  - Issue and response together leave outstanding unchanged.
- Redirect (highest priority):
  - In the redirect_i cycle, no request is issued and no pop occurs.
  - Next edge: FIFO emptied; pc_fetch_r = {redirect_pc_i[31:2], 2'b00}.
  - Next edge: discard = outstanding + (issue this cycle ? 1 : 0) − (response this cycle ? 1 : 0).
  - A response in the redirect cycle is itself dropped.
  - Back-to-back redirects are legal; the last one wins and discard keeps accumulating correctly.
  - Fetching at the new PC starts the cycle after redirect_i, even while discard > 0.
- Reset asserted mid-operation clears all state immediately. Instruction memory is reset on the same signal.
- Counter widths: fifo_count, outstanding and discard are $clog2(DEPTH)+1 bits.

Test Plan:
- Reset release, imem ready always, 1-cycle response → addresses 0x0, 0x4, 0x8…; first valid_o 2 cycles after the first handshake; pc_o = 0x0, pc_plus4_o = 0x4.
- stall_i held high for 10 cycles → at most DEPTH = 4 requests issued (0x0..0xC), imem_req_valid_o drops to 0, FIFO holds 4 entries. Releasing stall yields 0x0, 0x4, 0x8, 0xC in order with no duplicates.
- 3-cycle response latency, 2 requests outstanding, redirect_i with redirect_pc_i = 0x100 → both stale responses dropped; next valid_o shows pc_o = 0x100 and inst = mem[0x100].
- redirect_pc_i = 0x0000_0206 → imem_add_o = 0x204.
- redirect_i asserted on two consecutive cycles (0x40 then 0x80) while responses are in flight → only 0x80-path instructions reach valid_o; discard returns to 0.
- pc_fetch_r = 0xFFFF_FFFC → next request address 0x0000_0000; pc_plus4_o of that entry = 0x0.
- resetn_i pulsed low with 3 entries buffered → valid_o = 0 asynchronously; after release, fetch resumes at RESET_PC.

Source files
------------

// File: rtl/rv32i_fetch_unit.sv
// RV32I instruction fetch stage: issues word-aligned imem requests, buffers
// {pc, inst} in a prefetch FIFO for decode, and drops stale responses after a redirect.
module rv32i_fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_add_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o
);
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned CW1 = CW + 1;
    localparam logic [CW:0] DEPTH_C = CW1'(DEPTH);

    logic [31:0]   pc_fetch_r;
    logic          active_r;
    logic [CW-1:0] fifo_count_r;
    logic [CW-1:0] outstanding_r;
    logic [CW-1:0] discard_r;
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] tag_wr_ptr_r;
    logic [PW-1:0] tag_rd_ptr_r;
    logic [31:0]   fifo_pc_r   [DEPTH];
    logic [31:0]   fifo_inst_r [DEPTH];
    logic [31:0]   tag_r       [DEPTH];

    logic          issue;
    logic          rsp_fire;
    logic          drop;
    logic          push;
    logic          pop;
    logic [CW:0]   inflight;
    logic [CW-1:0] outstanding_nxt;

    // Buffered plus in-flight words never exceed DEPTH, so every response has a FIFO slot.
    assign inflight         = {1'b0, fifo_count_r} + {1'b0, outstanding_r};
    assign imem_req_valid_o = active_r && !redirect_i && (inflight < DEPTH_C);
    assign imem_add_o       = pc_fetch_r;
    assign issue            = imem_req_valid_o && imem_req_ready_i;
    assign rsp_fire         = imem_rsp_valid_i && (outstanding_r != '0);
    assign drop             = redirect_i || (discard_r != '0);
    assign push             = rsp_fire && !drop;
    assign outstanding_nxt  = outstanding_r + CW'(issue) - CW'(rsp_fire);

    assign valid_o    = (fifo_count_r != '0) && !redirect_i;
    assign pop        = valid_o && !stall_i;
    assign inst_o     = fifo_inst_r[rd_ptr_r];
    assign pc_o       = fifo_pc_r[rd_ptr_r];
    assign pc_plus4_o = pc_o + 32'd4;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            pc_fetch_r    <= RESET_PC;
            active_r      <= 1'b0;
            fifo_count_r  <= '0;
            outstanding_r <= '0;
            discard_r     <= '0;
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            tag_wr_ptr_r  <= '0;
            tag_rd_ptr_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_r[i]   <= '0;
                fifo_inst_r[i] <= '0;
                tag_r[i]       <= '0;
            end
        end else begin
            active_r      <= 1'b1;
            outstanding_r <= outstanding_nxt;
            if (issue) begin
                tag_r[tag_wr_ptr_r] <= pc_fetch_r;
                tag_wr_ptr_r        <= tag_wr_ptr_r + PW'(1);
            end
            if (rsp_fire) begin
                tag_rd_ptr_r <= tag_rd_ptr_r + PW'(1);
            end
            // Everything still in flight at a redirect belongs to the old path.
            if (redirect_i) begin
                pc_fetch_r   <= {redirect_pc_i[31:2], 2'b00};
                discard_r    <= outstanding_nxt;
                fifo_count_r <= '0;
                wr_ptr_r     <= '0;
                rd_ptr_r     <= '0;
            end else begin
                if (issue) begin
                    pc_fetch_r <= pc_fetch_r + 32'd4;
                end
                if (rsp_fire && (discard_r != '0)) begin
                    discard_r <= discard_r - CW'(1);
                end
                if (push) begin
                    fifo_pc_r[wr_ptr_r]   <= tag_r[tag_rd_ptr_r];
                    fifo_inst_r[wr_ptr_r] <= imem_rsp_data_i;
                    wr_ptr_r              <= wr_ptr_r + PW'(1);
                end
                if (pop) begin
                    rd_ptr_r <= rd_ptr_r + PW'(1);
                end
                fifo_count_r <= fifo_count_r + CW'(push) - CW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Directed bench for rv32i_fetch_unit: in-order imem model with settable latency
// returning ~address as the instruction word; expected values are hand-computed.
module tb_rv32i_fetch_unit;
    logic        clk_i = 1'b0;
    logic        resetn_i;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_add_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;

    rv32i_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk_i            (clk_i),
        .resetn_i         (resetn_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_add_o       (imem_add_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .stall_i          (stall_i),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .valid_o          (valid_o),
        .inst_o           (inst_o),
        .pc_o             (pc_o),
        .pc_plus4_o       (pc_plus4_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        pend[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_inst[$];
    logic [31:0] got_p4[$];
    int          cyc = 0;
    int          lat = 1;
    int          hs_count = 0;
    int          first_hs_cyc = -1;
    int          errors = 0;
    int          checks = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] q_pc(input int i);
        return (got_pc.size() > i) ? got_pc[i] : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] q_inst(input int i);
        return (got_inst.size() > i) ? got_inst[i] : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] q_p4(input int i);
        return (got_p4.size() > i) ? got_p4[i] : 32'hDEAD_BEEF;
    endfunction

    // Instruction memory: handshake at edge n -> response sampled at edge n+lat+1.
    logic        mem_hs;
    logic [31:0] mem_addr;
    initial begin
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = '0;
        forever begin
            @(negedge clk_i);
            mem_hs   = imem_req_valid_o && imem_req_ready_i && resetn_i;
            mem_addr = imem_add_o;
            @(posedge clk_i);
            cyc++;
            if (!resetn_i) begin
                pend.delete();
            end else if (mem_hs) begin
                pend.push_back('{mem_addr, cyc + lat});
                hs_count++;
                if (first_hs_cyc < 0) first_hs_cyc = cyc;
            end
            #1;
            imem_rsp_valid_i = 1'b0;
            if (resetn_i && pend.size() > 0 && pend[0].due <= cyc) begin
                imem_rsp_valid_i = 1'b1;
                imem_rsp_data_i  = ~pend[0].addr;
                void'(pend.pop_front());
            end
        end
    end

    // Decode side: record every instruction actually consumed.
    initial begin
        forever begin
            @(negedge clk_i);
            if (resetn_i && valid_o && !stall_i) begin
                got_pc.push_back(pc_o);
                got_inst.push_back(inst_o);
                got_p4.push_back(pc_plus4_o);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic clear_log();
        got_pc.delete();
        got_inst.delete();
        got_p4.delete();
        hs_count     = 0;
        first_hs_cyc = -1;
    endtask

    task automatic do_reset();
        resetn_i   = 1'b0;
        redirect_i = 1'b0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        clear_log();
        resetn_i = 1'b1;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk_i); #1;
        end
    endtask

    task automatic wait_hs(input int n);
        for (int k = 0; k < 30 && hs_count < n; k++) begin
            @(posedge clk_i); #1;
        end
        if (hs_count < n) check_val("wait_hs", hs_count, n);
    endtask

    task automatic wait_valid(input string tag);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk_i);
            seen = valid_o;
        end
        check_val(tag, seen, 1'b1);
    endtask

    initial begin
        resetn_i         = 1'b0;
        imem_req_ready_i = 1'b1;
        stall_i          = 1'b0;
        redirect_i       = 1'b0;
        redirect_pc_i    = '0;
        #2;
        check_val("rst_req_valid", imem_req_valid_o, 1'b0);
        check_val("rst_valid", valid_o, 1'b0);
        check_val("rst_inst", inst_o, 32'h0);
        check_val("rst_pc", pc_o, 32'h0);
        check_val("rst_pc4", pc_plus4_o, 32'h4);

        // Streaming, 1-cycle memory
        lat = 1;
        do_reset();
        wait_valid("t1_valid");
        check_val("t1_latency", cyc - first_hs_cyc, 32'd2);
        check_val("t1_pc", pc_o, 32'h0);
        check_val("t1_pc4", pc_plus4_o, 32'h4);
        check_val("t1_inst", inst_o, 32'hFFFF_FFFF);
        cycles(6);
        check_val("t1_seq0", q_pc(0), 32'h0);
        check_val("t1_seq1", q_pc(1), 32'h4);
        check_val("t1_seq2", q_pc(2), 32'h8);
        check_val("t1_seq3", q_pc(3), 32'hC);
        check_val("t1_inst1", q_inst(1), 32'hFFFF_FFFB);

        // Decode stalled: issue stops at DEPTH
        stall_i = 1'b1;
        do_reset();
        cycles(10);
        @(negedge clk_i);
        check_val("t2_hs", hs_count, 32'd4);
        check_val("t2_req_valid", imem_req_valid_o, 1'b0);
        check_val("t2_valid", valid_o, 1'b1);
        check_val("t2_head", pc_o, 32'h0);
        @(posedge clk_i); #1;
        imem_req_ready_i = 1'b0;
        stall_i          = 1'b0;
        cycles(8);
        check_val("t2_npop", got_pc.size(), 32'd4);
        check_val("t2_seq0", q_pc(0), 32'h0);
        check_val("t2_seq1", q_pc(1), 32'h4);
        check_val("t2_seq2", q_pc(2), 32'h8);
        check_val("t2_seq3", q_pc(3), 32'hC);
        imem_req_ready_i = 1'b1;

        // Redirect with two stale responses in flight
        lat = 3;
        do_reset();
        wait_hs(2);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h100;
        @(posedge clk_i); #1;
        redirect_i = 1'b0;
        wait_valid("t3_valid");
        check_val("t3_pc", pc_o, 32'h100);
        check_val("t3_inst", inst_o, 32'hFFFF_FEFF);
        check_val("t3_pc4", pc_plus4_o, 32'h104);
        cycles(6);
        check_val("t3_seq0", q_pc(0), 32'h100);
        check_val("t3_seq1", q_pc(1), 32'h104);

        // Misaligned redirect target is word-aligned
        @(posedge clk_i); #1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0206;
        @(negedge clk_i);
        check_val("t4_rd_noissue", imem_req_valid_o, 1'b0);
        check_val("t4_rd_novalid", valid_o, 1'b0);
        @(posedge clk_i); #1;
        redirect_i = 1'b0;
        @(negedge clk_i);
        check_val("t4_addr", imem_add_o, 32'h204);

        // Back-to-back redirects, last one wins
        lat = 3;
        do_reset();
        wait_hs(2);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h40;
        @(posedge clk_i); #1;
        redirect_pc_i = 32'h80;
        @(posedge clk_i); #1;
        redirect_i = 1'b0;
        cycles(15);
        check_val("t5_seq0", q_pc(0), 32'h80);
        check_val("t5_seq1", q_pc(1), 32'h84);
        check_val("t5_seq2", q_pc(2), 32'h88);
        check_val("t5_inst0", q_inst(0), 32'hFFFF_FF7F);

        // Fetch address wraps at 2^32
        lat = 1;
        do_reset();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        @(posedge clk_i); #1;
        redirect_i = 1'b0;
        @(negedge clk_i);
        check_val("t6_addr0", imem_add_o, 32'hFFFF_FFFC);
        @(posedge clk_i);
        @(negedge clk_i);
        check_val("t6_addr1", imem_add_o, 32'h0);
        cycles(6);
        check_val("t6_pc0", q_pc(0), 32'hFFFF_FFFC);
        check_val("t6_p40", q_p4(0), 32'h0);
        check_val("t6_pc1", q_pc(1), 32'h0);
        check_val("t6_inst1", q_inst(1), 32'hFFFF_FFFF);

        // Asynchronous reset with three entries buffered
        lat     = 1;
        stall_i = 1'b1;
        do_reset();
        wait_hs(3);
        imem_req_ready_i = 1'b0;
        cycles(4);
        @(negedge clk_i);
        check_val("t7_pre_valid", valid_o, 1'b1);
        @(posedge clk_i); #2;
        resetn_i = 1'b0;
        #1;
        check_val("t7_async_valid", valid_o, 1'b0);
        check_val("t7_async_pc4", pc_plus4_o, 32'h4);
        @(posedge clk_i); #1;
        clear_log();
        imem_req_ready_i = 1'b1;
        stall_i          = 1'b0;
        resetn_i         = 1'b1;
        wait_valid("t7_valid");
        check_val("t7_pc", pc_o, 32'h0);
        cycles(3);
        check_val("t7_seq0", q_pc(0), 32'h0);
        check_val("t7_seq1", q_pc(1), 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
